// File: rtl/reg_issue_ctrl_if.sv
// reg_issue_ctrl_if: decode/writeback/flush bundle between the pipeline and the issue controller.
interface reg_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  localparam int ADDR_WIDTH = $clog2(WIDTH);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] rnum1;
  logic [ADDR_WIDTH-1:0] rnum2;
  logic                  use_r1;
  logic                  use_r2;
  logic [ADDR_WIDTH-1:0] wnum;
  logic                  is_write_reg;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_num;
  logic                  flush;
  logic [1:0]            state;
  logic [3:0]            inflight;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  err_wb;
  modport master (
    output issue_valid, rnum1, rnum2, use_r1, use_r2, wnum, is_write_reg, wb_valid, wb_num, flush,
    input  issue_ready, state, inflight, stall_cnt, err_wb
  );
  modport slave (
    input  issue_valid, rnum1, rnum2, use_r1, use_r2, wnum, is_write_reg, wb_valid, wb_num, flush,
    output issue_ready, state, inflight, stall_cnt, err_wb
  );
endinterface

// File: rtl/reg_issue_ctrl.sv
// reg_issue_ctrl: register scoreboard issue control with busy bits, in-flight write limit,
// flush/drain state machine, saturating stall counter and writeback error pulse.
module reg_issue_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst_n,
  reg_issue_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_busy;
  logic [3:0]       r_inflight;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err_wb;
  logic [WIDTH-1:0] w_wb_oh, w_eff, w_set, w_clr;
  logic             w_wb_hit, w_cap, w_hazard, w_ready, w_fire, w_inc, w_dec;
  assign w_wb_oh  = bus.wb_valid ? (WIDTH'(1) << bus.wb_num) : '0;
  assign w_wb_hit = bus.wb_valid & r_busy[bus.wb_num];
  // Same-cycle writeback releases the hazard on its register.
  assign w_eff    = r_busy & ~w_wb_oh;
  assign w_cap    = bus.is_write_reg & (bus.wnum != '0) & (r_inflight == 4'(MAX_INFLIGHT)) & ~w_wb_hit;
  assign w_hazard = (bus.use_r1 & w_eff[bus.rnum1]) | (bus.use_r2 & w_eff[bus.rnum2]) |
                    (bus.is_write_reg & w_eff[bus.wnum]) | w_cap;
  assign w_ready  = (r_state != FLUSH) & ~w_hazard & ~bus.flush;
  assign w_fire   = bus.issue_valid & w_ready;
  assign w_set    = (w_fire & bus.is_write_reg & (bus.wnum != '0)) ? (WIDTH'(1) << bus.wnum) : '0;
  assign w_clr    = w_wb_hit ? w_wb_oh : '0;
  assign w_inc    = |w_set;
  assign w_dec    = w_wb_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_busy      <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_err_wb    <= 1'b0;
    end else begin
      r_busy     <= (r_busy & ~w_clr) | w_set;
      r_inflight <= (w_inc & ~w_dec) ? r_inflight + 4'd1 :
                    (w_dec & ~w_inc) ? r_inflight - 4'd1 : r_inflight;
      r_err_wb   <= bus.wb_valid & ~r_busy[bus.wb_num];
      if (bus.issue_valid & ~w_ready & ~(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        RUN:     r_state <= bus.flush ? FLUSH : (bus.issue_valid & ~w_ready) ? STALL : RUN;
        STALL:   r_state <= bus.flush ? FLUSH : (w_fire | ~bus.issue_valid) ? RUN : STALL;
        FLUSH:   r_state <= ((r_inflight == '0) & (r_busy == '0)) ? RUN : FLUSH;
        default: r_state <= RUN;
      endcase
    end
  end
  assign bus.issue_ready = w_ready;
  assign bus.state       = r_state;
  assign bus.inflight    = r_inflight;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.err_wb      = r_err_wb;
endmodule
